// File: rtl/srl_seq_pkg.sv
// Shared types for the sequential right shifter: FSM states, fill modes, datapath width.
package shift_pkg;

  localparam int SHIFT_W = 32;
  localparam int SHAMT_W = $clog2(SHIFT_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } srl_state_t;

  typedef enum logic [1:0] {
    FILL_ZERO = 2'd0,
    FILL_SIGN = 2'd1,
    FILL_ROT  = 2'd2
  } fill_mode_t;

endpackage

// File: rtl/srl_seq_if.sv
// Start/ready request and done/result bundle for srl_seq.
// SRL_SEQ_ROTR_EN adds the rotate request bit.
interface srl_seq_if;
  import shift_pkg::*;

  logic               start;
  logic [SHIFT_W-1:0] data;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
`ifdef SRL_SEQ_ROTR_EN
  logic               rotate;
`endif
  logic               ready;
  logic               busy;
  logic [SHIFT_W-1:0] out;
  logic               done;

  modport master (
    output start, data, shamt, arith,
`ifdef SRL_SEQ_ROTR_EN
    output rotate,
`endif
    input  ready, busy, out, done
  );

  modport slave (
    input  start, data, shamt, arith,
`ifdef SRL_SEQ_ROTR_EN
    input  rotate,
`endif
    output ready, busy, out, done
  );

endinterface

// File: rtl/srl_seq_rshift_step.sv
// One iteration of the right shifter: shifts by 0, 1 or 2 bits with zero, sign or rotate fill.
module rshift_step
  import shift_pkg::*;
(
  input  logic [SHIFT_W-1:0] acc,
  input  logic [1:0]         step,
  input  fill_mode_t         fill,
  output logic [SHIFT_W-1:0] nxt
);

  logic [1:0] fill_bits;

  // fill_bits[1] lands in the MSB; for rotation it is whatever leaves the LSB end
  always_comb begin
    fill_bits = 2'b00;
    case (fill)
      FILL_SIGN: fill_bits = {2{acc[SHIFT_W-1]}};
      FILL_ROT:  fill_bits = (step == 2'd1) ? {acc[0], 1'b0} : acc[1:0];
      default:   fill_bits = 2'b00;
    endcase
  end

  always_comb begin
    nxt = acc;
    case (step)
      2'd1:    nxt = {fill_bits[1], acc[SHIFT_W-1:1]};
      2'd2:    nxt = {fill_bits, acc[SHIFT_W-1:2]};
      default: nxt = acc;
    endcase
  end

endmodule

// File: rtl/srl_seq.sv
// Multi-cycle right shifter (SRL/SRA, optional ROTR when SRL_SEQ_ROTR_EN is defined),
// retiring up to STEP bits per clock behind a start/ready, done-pulse handshake.
module srl_seq
  import shift_pkg::*;
#(
  parameter int STEP = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  srl_seq_if.slave  bus
);

  srl_state_t         state_reg, state_next;
  logic [SHIFT_W-1:0] acc_reg, acc_next;
  logic [SHAMT_W-1:0] rem_reg, rem_next;
  fill_mode_t         mode_reg, mode_next;
  logic [SHIFT_W-1:0] out_reg, out_next;

  logic [1:0]         step_sel;
  logic [SHIFT_W-1:0] acc_shifted;
  fill_mode_t         fill_sel;

  always_comb begin
`ifdef SRL_SEQ_ROTR_EN
    if (bus.rotate)         fill_sel = FILL_ROT;
    else if (bus.arith)     fill_sel = FILL_SIGN;
    else                    fill_sel = FILL_ZERO;
`else
    fill_sel = bus.arith ? FILL_SIGN : FILL_ZERO;
`endif
  end

  // Take the full STEP while enough bits remain, otherwise finish the odd remainder
  assign step_sel = (rem_reg >= SHAMT_W'(STEP)) ? 2'(STEP) : rem_reg[1:0];

  rshift_step u_step (
    .acc  (acc_reg),
    .step (step_sel),
    .fill (mode_reg),
    .nxt  (acc_shifted)
  );

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    rem_next   = rem_reg;
    mode_next  = mode_reg;
    out_next   = out_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          acc_next  = bus.data;
          rem_next  = bus.shamt;
          mode_next = fill_sel;
          if (bus.shamt == '0) begin
            state_next = DONE;
            out_next   = bus.data;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_next = acc_shifted;
        rem_next = rem_reg - SHAMT_W'(step_sel);
        // out is loaded on the edge into DONE so it is valid alongside the done pulse
        if (rem_next == '0) begin
          state_next = DONE;
          out_next   = acc_shifted;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      rem_reg   <= '0;
      mode_reg  <= FILL_ZERO;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      rem_reg   <= rem_next;
      mode_reg  <= mode_next;
      out_reg   <= out_next;
    end
  end

  assign bus.ready = (state_reg == IDLE);
  assign bus.busy  = (state_reg == SHIFT) || (state_reg == DONE);
  assign bus.done  = (state_reg == DONE);
  assign bus.out   = out_reg;

endmodule

// File: tb/tb_srl_seq.sv
// Self-checking bench for srl_seq: directed table, handshake corner sequences, random ops vs. model.
module tb_srl_seq;

  localparam int STEP_TB = 2;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  logic [31:0] prev_out;
  logic last_rot;

  srl_seq_if bus_if ();

  srl_seq #(.STEP(STEP_TB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic        arith;
    logic        rot;
    logic [31:0] exp_out;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                            input logic a, input logic r);
    logic [63:0] dd;
    if (r) begin
      dd = {d, d} >> s;
      return dd[31:0];
    end
    if (a) return 32'($signed(d) >>> s);
    return d >> s;
  endfunction

  function automatic int ref_lat(input logic [4:0] s);
    return 1 + (int'(s) + STEP_TB - 1) / STEP_TB;
  endfunction

  // Launch one request, wait for done (bounded), check out holds during SHIFT and ready follows
  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a, input logic r,
                        output logic [31:0] res, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus_if.ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus_if.start = 1'b1;
    bus_if.data  = d;
    bus_if.shamt = s;
    bus_if.arith = a;
`ifdef SRL_SEQ_ROTR_EN
    bus_if.rotate = r;
`endif
    last_rot = r;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.data  = $urandom;
    bus_if.shamt = 5'($urandom);
    bus_if.arith = 1'($urandom);
    lat = 1;
    while (!bus_if.done && lat < 40) begin
      check("out_hold", bus_if.out, prev_out);
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_seen", {31'd0, bus_if.done}, 32'd1);
    res = bus_if.out;
    prev_out = res;
    @(posedge clk);
    #1;
    check("ready_after_done", {31'd0, bus_if.ready}, 32'd1);
    check("done_one_cycle", {31'd0, bus_if.done}, 32'd0);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] exp_o;
    logic [31:0] rd;
    logic [4:0]  rs;
    logic        ra;
    logic        rr;
    int          lat;
    int          cyc;
    int          ndone;
    int          done_at[$];

    checks   = 0;
    failures = 0;
    prev_out = 32'd0;
    last_rot = 1'b0;
    bus_if.start = 1'b0;
    bus_if.data  = 32'd0;
    bus_if.shamt = 5'd0;
    bus_if.arith = 1'b0;
`ifdef SRL_SEQ_ROTR_EN
    bus_if.rotate = 1'b0;
`endif

    vecs.push_back('{32'h80000000, 5'd31, 1'b0, 1'b0, 32'h00000001, 17});
    vecs.push_back('{32'h80000000, 5'd31, 1'b1, 1'b0, 32'hFFFFFFFF, 17});
    vecs.push_back('{32'h7FFFFFF0, 5'd4,  1'b1, 1'b0, 32'h07FFFFFF, 3});
    vecs.push_back('{32'h12345678, 5'd0,  1'b0, 1'b0, 32'h12345678, 1});
    vecs.push_back('{32'h12345678, 5'd1,  1'b0, 1'b0, 32'h091A2B3C, 2});
    vecs.push_back('{32'hF0000000, 5'd3,  1'b1, 1'b0, 32'hFE000000, 3});
    vecs.push_back('{32'hF0000000, 5'd3,  1'b0, 1'b0, 32'h1E000000, 3});
`ifdef SRL_SEQ_ROTR_EN
    vecs.push_back('{32'h00000001, 5'd1,  1'b0, 1'b1, 32'h80000000, 2});
    vecs.push_back('{32'h0000000F, 5'd2,  1'b0, 1'b1, 32'hC0000003, 2});
    vecs.push_back('{32'h80000001, 5'd31, 1'b1, 1'b1, 32'h00000003, 17});
`endif

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, bus_if.ready}, 32'd1);
    check("reset_busy", {31'd0, bus_if.busy}, 32'd0);
    check("reset_done", {31'd0, bus_if.done}, 32'd0);
    check("reset_out", bus_if.out, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].data, vecs[i].shamt, vecs[i].arith, vecs[i].rot, res, lat);
      $display("vec %0d data=%h shamt=%0d arith=%0b rot=%0b out=%h lat=%0d",
               i, vecs[i].data, vecs[i].shamt, vecs[i].arith, vecs[i].rot, res, lat);
      check($sformatf("vec%0d_out", i), res, vecs[i].exp_out);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // start pulsed mid-SHIFT must be ignored
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.data  = 32'hFF000000;
    bus_if.shamt = 5'd8;
    bus_if.arith = 1'b0;
`ifdef SRL_SEQ_ROTR_EN
    bus_if.rotate = 1'b0;
`endif
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    ndone = 0;
    lat   = 0;
    res   = 32'd0;
    for (int c = 1; c <= 15; c++) begin
      if (c == 2) begin
        bus_if.start = 1'b1;
        bus_if.data  = 32'hDEADBEEF;
        bus_if.shamt = 5'd1;
      end else begin
        bus_if.start = 1'b0;
      end
      if (bus_if.done) begin
        ndone++;
        lat = c;
        res = bus_if.out;
      end else if (ndone == 0) begin
        check("busy_out_hold", bus_if.out, prev_out);
      end
      @(posedge clk);
      #1;
    end
    bus_if.start = 1'b0;
    $display("busy_ignore out=%h done_count=%0d lat=%0d", res, ndone, lat);
    check("busy_ignore_out", res, 32'h00FF0000);
    check("busy_ignore_count", 32'(ndone), 32'd1);
    check("busy_ignore_lat", 32'(lat), 32'd5);
    prev_out = res;

    // start held high: accepted once per IDLE visit, spaced latency+1
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.data  = 32'h0000F000;
    bus_if.shamt = 5'd2;
    bus_if.arith = 1'b0;
    done_at.delete();
    res = 32'd0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) begin
        done_at.push_back(c);
        res = bus_if.out;
      end
    end
    bus_if.start = 1'b0;
    @(posedge clk);
    #1;
    $display("held_start dones=%0d out=%h", done_at.size(), res);
    check("held_count", 32'(done_at.size()), 32'd3);
    if (done_at.size() >= 2) begin
      check("held_first", 32'(done_at[0]), 32'd2);
      check("held_spacing", 32'(done_at[1] - done_at[0]), 32'd3);
    end
    check("held_out", res, 32'h00003C00);
    prev_out = res;

    // asynchronous reset at cycle 3 of a long operation
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.data  = 32'hABCD1234;
    bus_if.shamt = 5'd20;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_out", bus_if.out, 32'd0);
    check("abort_done", {31'd0, bus_if.done}, 32'd0);
    check("abort_ready", {31'd0, bus_if.ready}, 32'd1);
    check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    prev_out = 32'd0;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) ndone++;
    end
    $display("abort spurious_dones=%0d", ndone);
    check("abort_no_done", 32'(ndone), 32'd0);
    run_op(32'hABCD1234, 5'd20, 1'b1, 1'b0, res, lat);
    $display("after_abort out=%h lat=%0d", res, lat);
    check("after_abort_out", res, 32'hFFFFFABC);
    check("after_abort_lat", 32'(lat), 32'd11);

    // randomized operations against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      rd = $urandom;
      rs = 5'($urandom_range(0, 31));
      ra = 1'($urandom);
`ifdef SRL_SEQ_ROTR_EN
      rr = 1'($urandom);
`else
      rr = 1'b0;
`endif
      exp_o = ref_shift(rd, rs, ra, rr);
      run_op(rd, rs, ra, rr, res, lat);
      $display("rand %0d data=%h shamt=%0d arith=%0b rot=%0b out=%h lat=%0d",
               n, rd, rs, ra, rr, res, lat);
      check("rand_out", res, exp_o);
      check("rand_lat", 32'(lat), 32'(ref_lat(rs)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
